// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
//
// Exhaustive truth-table sweeper for a combinational gate under test. A Start
// pulse in IDLE launches a sweep over every input vector 0 .. 2^N_IN-1. Each
// vector is held for SETTLE+1 cycles. The gate output is sampled at the last
// edge of that window and compared against TRUTH. At the end of the sweep a
// one-cycle Done pulse is issued and a pass/fail summary is kept.
//
// Parameters
//   N_IN    gate input count (1..4)
//   TRUTH   expected truth table; bit i is the output for input vector i
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//
// Ports
//   CLK            clock; all state changes happen on the rising edge
//   RST            asynchronous, active-high reset
//   Start          begins a sweep; only looked at while IDLE
//   Gate_Out       output of the gate under test
//   Gate_In        input vector driven onto the gate under test
//   Busy           high while a sweep is running
//   Done           one-cycle pulse after the final compare
//   Pass           1 when the last completed sweep had no mismatches
//   Err_Count      number of mismatching vectors in the current or last sweep
//   First_Err_Vec  first mismatching vector; valid only when Err_Count != 0
// -----------------------------------------------------------------------------
module gate_sweep_checker #(
  parameter int                     N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b0111,
  parameter int                     SETTLE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Gate_Out,
  output logic [N_IN-1:0] Gate_In,
  output logic            Busy,
  output logic            Done,
  output logic            Pass,
  output logic [N_IN:0]   Err_Count,
  output logic [N_IN-1:0] First_Err_Vec
);

  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [N_IN-1:0] gin_q,    gin_d;
  logic [3:0]      settle_q, settle_d;
  logic [N_IN:0]   err_q,    err_d;
  logic [N_IN-1:0] first_q,  first_d;
  logic            pass_q,   pass_d;

  logic            mismatch;
  logic [N_IN:0]   err_after;

  // Case-inequality so that X/Z on the gate output counts as a mismatch in
  // simulation; in hardware it reduces to an ordinary inequality.
  assign mismatch  = (Gate_Out !== TRUTH[gin_q]);
  assign err_after = err_q + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      gin_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      first_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gin_q    <= gin_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      first_q  <= first_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gin_d    = gin_q;
    settle_d = settle_q;
    err_d    = err_q;
    first_d  = first_q;
    pass_d   = pass_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = RUN;
          gin_d    = '0;
          settle_d = SETTLE_L;
          err_d    = '0;
          first_d  = '0;
          pass_d   = 1'b0;
        end
      end

      RUN: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          // Last edge of this vector's hold window: compare and advance.
          err_d = err_after;
          if (mismatch && (err_q == '0)) begin
            first_d = gin_q;
          end
          if (gin_q == LAST_VEC) begin
            state_d = DONE;
            gin_d   = '0;
            pass_d  = (err_after == '0);
          end else begin
            gin_d    = gin_q + 1'b1;
            settle_d = SETTLE_L;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Gate_In       = gin_q;
  assign Busy          = (state_q == RUN);
  assign Done          = (state_q == DONE);
  assign Pass          = pass_q;
  assign Err_Count     = err_q;
  assign First_Err_Vec = first_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// Bench for gate_sweep_checker. Two instances: the default 2-input NAND
// checker and a 3-input NAND checker with SETTLE=3. Each gate under test is a
// lookup table driven by the bench; expected counts are derived from the
// number of differing table bits and the lowest differing index.
// -----------------------------------------------------------------------------
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: defaults
  logic       start0 = 1'b0;
  logic [3:0] tbl0   = 4'b0111;
  logic [1:0] gin0;
  logic       busy0, done0, pass0;
  logic [2:0] err0;
  logic [1:0] first0;

  // instance 1: N_IN=3, SETTLE=3
  logic       start1 = 1'b0;
  logic [7:0] tbl1   = 8'h7F;
  logic [2:0] gin1;
  logic       busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] first1;

  gate_sweep_checker u_dut0 (
    .CLK(clk), .RST(rst), .Start(start0), .Gate_Out(tbl0[gin0]),
    .Gate_In(gin0), .Busy(busy0), .Done(done0), .Pass(pass0),
    .Err_Count(err0), .First_Err_Vec(first0)
  );

  gate_sweep_checker #(.N_IN(3), .TRUTH(8'h7F), .SETTLE(3)) u_dut1 (
    .CLK(clk), .RST(rst), .Start(start1), .Gate_Out(tbl1[gin1]),
    .Gate_In(gin1), .Busy(busy1), .Done(done1), .Pass(pass1),
    .Err_Count(err1), .First_Err_Vec(first1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // observed outputs of the selected instance
  int o_gin, o_busy, o_done, o_pass, o_err, o_first;
  task automatic sample(input int which);
    if (which == 0) begin
      o_gin = int'(gin0); o_busy = int'(busy0); o_done = int'(done0);
      o_pass = int'(pass0); o_err = int'(err0); o_first = int'(first0);
    end else begin
      o_gin = int'(gin1); o_busy = int'(busy1); o_done = int'(done1);
      o_pass = int'(pass1); o_err = int'(err1); o_first = int'(first1);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start0 = v; else start1 = v;
  endtask

  // Reference: errors = vectors where the gate table differs from the
  // expected truth table; first error = lowest such vector.
  int e_err, e_first, e_pass;
  task automatic model(input int which);
    int nv;
    int truth;
    int tbl;
    nv    = (which == 0) ? 4 : 8;
    truth = (which == 0) ? 'h7 : 'h7F;
    tbl   = (which == 0) ? int'(tbl0) : int'(tbl1);
    e_err = 0; e_first = 0;
    for (int v = 0; v < nv; v++) begin
      if (((tbl >> v) & 1) != ((truth >> v) & 1)) begin
        if (e_err == 0) e_first = v;
        e_err++;
      end
    end
    e_pass = (e_err == 0) ? 1 : 0;
  endtask

  // summary values held from the last completed sweep of each instance
  int h_pass[2]  = '{0, 0};
  int h_err[2]   = '{0, 0};
  int h_first[2] = '{0, 0};
  int last_done  = -1;

  // One sweep. Entered just before a negedge where the instance is IDLE (or
  // about to be, with Start held), leaves at the negedge after the Done edge.
  // With hold=1 Start stays high so the next call lines up back to back;
  // otherwise Start is toggled randomly while Busy to show it is ignored.
  // stop_at >= 0 returns early once that vector is being driven.
  task automatic sweep(input int which, input bit hold, input int stop_at);
    int s, nv, len;
    s   = (which == 0) ? 1 : 3;
    nv  = (which == 0) ? 4 : 8;
    len = nv * (s + 1);
    model(which);
    @(negedge clk);
    sample(which);
    check("idle_done", o_done, 0);
    check("idle_busy", o_busy, 0);
    check("idle_pass_hold", o_pass, h_pass[which]);
    check("idle_err_hold", o_err, h_err[which]);
    if (h_err[which] != 0) check("idle_first_hold", o_first, h_first[which]);
    set_start(which, 1'b1);
    @(posedge clk);                           // E0
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (!hold) set_start(which, 1'($urandom_range(0, 1)));
      sample(which);
      check("run_gin", o_gin, j / (s + 1));
      check("run_busy", o_busy, 1);
      check("run_done", o_done, 0);
      if (j == 0) check("run_err_clear", o_err, 0);
      if (j / (s + 1) == stop_at) return;
    end
    @(negedge clk);                           // after E0 + len
    if (!hold) set_start(which, 1'b0);
    sample(which);
    check("done_pulse", o_done, 1);
    check("done_busy", o_busy, 0);
    check("done_gin", o_gin, 0);
    check("done_pass", o_pass, e_pass);
    check("done_err", o_err, e_err);
    if (e_err != 0) check("done_first", o_first, e_first);
    if (hold && last_done >= 0) check("done_period", cyc - last_done, len + 2);
    last_done = cyc;
    h_pass[which] = e_pass; h_err[which] = e_err; h_first[which] = e_first;
    $display("sweep dut%0d tbl=%h err=%0d first=%0d pass=%0d", which,
             (which == 0) ? int'(tbl0) : int'(tbl1), o_err, o_first, o_pass);
  endtask

  initial begin
    // reset state
    #2;
    sample(0);
    check("rst_gin", o_gin, 0);   check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0); check("rst_pass", o_pass, 0);
    check("rst_err", o_err, 0);   check("rst_first", o_first, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // directed defaults: ideal NAND, stuck-at-1, AND
    tbl0 = 4'b0111; sweep(0, 1'b0, -1);
    tbl0 = 4'b1111; sweep(0, 1'b0, -1);
    tbl0 = 4'b1000; sweep(0, 1'b0, -1);
    // random gate behaviours
    for (int k = 0; k < 6; k++) begin
      tbl0 = 4'($urandom);
      sweep(0, 1'b0, -1);
    end

    // 3-input NAND, SETTLE=3, then random tables
    tbl1 = 8'h7F; sweep(1, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      tbl1 = 8'($urandom);
      sweep(1, 1'b0, -1);
    end

    // reset while Gate_In=2: outputs clear before the next edge
    tbl0 = 4'b0111;
    sweep(0, 1'b0, 2);
    #2 rst = 1'b1;
    #1 sample(0);
    check("arst_gin", o_gin, 0);   check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0); check("arst_pass", o_pass, 0);
    check("arst_err", o_err, 0);   check("arst_first", o_first, 0);
    set_start(0, 1'b0);
    h_pass[0] = 0; h_err[0] = 0; h_first[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 1'b0, -1);

    // Start held high: back-to-back sweeps, table changed between sweeps
    last_done = -1;
    for (int k = 0; k < 4; k++) begin
      tbl0 = (k == 0) ? 4'b1000 : 4'($urandom);
      sweep(0, 1'b1, -1);
    end
    start0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
